// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: assembles MSB- or LSB-first bit streams into a
// WIDTH-bit word and offers it on a valid/ready handshake, flagging overrun.
module serial_to_parallel_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             lsb_first,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;
  logic             do_start;

  // Next-state and output computation
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    do_start = 1'b0;
    shifted  = dir_q ? {serial_in, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], serial_in};

    case (state_q)
      IDLE: begin
        do_start = start;
      end
      RECV: begin
        if (start) begin
          do_start = 1'b1;
        end else if (bit_valid) begin
          sr_d = shifted;
          if (cnt_q == CW'(WIDTH - 1)) begin
            data_d  = shifted;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          valid_d  = 1'b0;
          state_d  = IDLE;
          do_start = start;
        end else if (bit_valid) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A start that is acted on opens a fresh frame from any state
    if (do_start) begin
      dir_d   = lsb_first;
      sr_d    = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
      state_d = RECV;
    end

    busy_d = (state_d == RECV);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: directed scenarios plus random frames, with
// expected words queued by the driver and checked by an independent monitor.
module tb_serial_to_parallel_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         lsb_first = 1'b0;
  logic         bit_valid = 1'b0;
  logic         serial_in = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic         hold = 1'b0;
  logic [W-1:0] held = '0;

  serial_to_parallel_rx #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .lsb_first(lsb_first),
    .bit_valid(bit_valid), .serial_in(serial_in), .out_ready(out_ready),
    .data_out(data_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: the i-th received bit lands at position i (LSB-first) or W-1-i (MSB-first)
  function automatic logic [W-1:0] model(input logic lsb, input logic [W-1:0] stream);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb) w[i] = stream[W-1-i];
      else     w[W-1-i] = stream[W-1-i];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic lsb);
    start = 1'b1;
    lsb_first = lsb;
    tick();
    start = 1'b0;
    lsb_first = 1'b0;
  endtask

  // Transmit the first n bits of stream, stream[W-1] first
  task automatic send_bits(input logic [W-1:0] stream, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      serial_in = stream[W-1-i];
      tick();
      bit_valid = 1'b0;
      serial_in = 1'b0;
      if (i != n - 1) repeat (gap) tick();
    end
  endtask

  task automatic wait_accept(input bit rnd);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got out_valid=0 expected 1 within 200 cycles");
    end
    n = 0;
    while (out_valid && n < 200) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b0;
    if (out_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_accept: got out_valid=1 expected 0 within 200 cycles");
    end
  endtask

  // Monitor: compares each accepted word with the queue, and checks data hold
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold && out_valid) check("hold_data", 32'(data_out), 32'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word: got %0h expected none", data_out);
        end else begin
          check("word", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
      hold = out_valid && !out_ready;
      held = data_out;
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    logic [W-1:0] s;
    logic         l;

    // Reset state
    #12;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    reset_n = 1'b1;
    tick();

    // MSB-first A5, consecutive bits
    pulse_start(1'b0);
    check("t1_busy", 32'(busy), 32'h1);
    exp_q.push_back(8'hA5);
    send_bits(8'b10100101, 8, 0);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_busy_full", 32'(busy), 32'h0);
    check("t1_data", 32'(data_out), 32'hA5);
    wait_accept(1'b0);
    check("t1_idle_busy", 32'(busy), 32'h0);

    // LSB-first: palindrome A5, then 1,1,0.. -> 03
    pulse_start(1'b1);
    exp_q.push_back(8'hA5);
    send_bits(8'b10100101, 8, 0);
    wait_accept(1'b0);
    pulse_start(1'b1);
    exp_q.push_back(8'h03);
    send_bits(8'b11000000, 8, 0);
    wait_accept(1'b0);

    // Gapped bits and a stalled consumer
    pulse_start(1'b0);
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8, 2);
    for (int i = 0; i < 5; i++) begin
      check("t3_valid_held", 32'(out_valid), 32'h1);
      check("t3_data_held", 32'(data_out), 32'h3C);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_valid_drop", 32'(out_valid), 32'h0);
    check("t3_idle", 32'(busy), 32'h0);

    // Overrun while a word waits, sticky through accept, cleared by start
    pulse_start(1'b0);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8, 0);
    check("t4_ovr_pre", 32'(overrun), 32'h0);
    bit_valid = 1'b1;
    serial_in = 1'b1;
    tick();
    bit_valid = 1'b0;
    serial_in = 1'b0;
    check("t4_ovr_set", 32'(overrun), 32'h1);
    check("t4_data_kept", 32'(data_out), 32'h5A);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_start_ignored", 32'(out_valid), 32'h1);
    check("t4_ovr_still", 32'(overrun), 32'h1);
    wait_accept(1'b0);
    check("t4_ovr_sticky", 32'(overrun), 32'h1);
    pulse_start(1'b0);
    check("t4_ovr_clr", 32'(overrun), 32'h0);

    // Restart discards a partial word
    pulse_start(1'b0);
    send_bits(8'hF0, 4, 0);
    pulse_start(1'b0);
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8, 0);
    wait_accept(1'b0);

    // Asynchronous reset mid-frame and mid-handshake
    pulse_start(1'b0);
    send_bits(8'hFF, 5, 0);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst1_busy", 32'(busy), 32'h0);
    check("t6_rst1_valid", 32'(out_valid), 32'h0);
    reset_n = 1'b1;
    tick();
    pulse_start(1'b0);
    send_bits(8'hC3, 8, 0);
    check("t6_full", 32'(out_valid), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst2_valid", 32'(out_valid), 32'h0);
    check("t6_rst2_data", 32'(data_out), 32'h0);
    check("t6_rst2_ovr", 32'(overrun), 32'h0);
    reset_n = 1'b1;
    tick();
    pulse_start(1'b0);
    exp_q.push_back(8'hFF);
    send_bits(8'hFF, 8, 0);
    wait_accept(1'b0);

    // Random frames with random direction, gaps, restarts and back-pressure
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_start(1'($urandom_range(0, 1)));
        send_bits(W'($urandom), $urandom_range(1, W - 1), $urandom_range(0, 2));
      end
      l = 1'($urandom_range(0, 1));
      s = W'($urandom);
      pulse_start(l);
      exp_q.push_back(model(l, s));
      send_bits(s, W, $urandom_range(0, 2));
      wait_accept(1'b1);
    end
    check("end_ovr", 32'(overrun), 32'h0);
    check("end_queue", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
